// File: rtl/trigger_filter.sv
// trigger_filter: conditions the raw hardware trigger line before trigger_delay.
// The line is synchronised with two flops, glitch-filtered with separate rise and
// fall widths, and turned into a one-clock pulse on the selected active edge.
// Accepted pulses are counted for register readback.
module trigger_filter #(
    parameter int FILTER_WIDTH   = 16,
    parameter int TRIG_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_trigger_mode,
    input  logic                      i_trigger_activation,
    input  logic [FILTER_WIDTH-1:0]   iv_filter_rise,
    input  logic [FILTER_WIDTH-1:0]   iv_filter_fall,
    input  logic                      i_din,
    output logic                      o_level,
    output logic                      o_dout,
    output logic [TRIG_CNT_WIDTH-1:0] ov_trigger_cnt
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } state_t;

    localparam logic [FILTER_WIDTH-1:0]   FCNT_ZERO = FILTER_WIDTH'(0);
    localparam logic [FILTER_WIDTH-1:0]   FCNT_ONE  = FILTER_WIDTH'(1);
    localparam logic [TRIG_CNT_WIDTH-1:0] TCNT_ZERO = TRIG_CNT_WIDTH'(0);
    localparam logic [TRIG_CNT_WIDTH-1:0] TCNT_ONE  = TRIG_CNT_WIDTH'(1);

    // Synchroniser and filter state
    logic                      din_ff1_q;
    logic                      din_sync_q;
    state_t                    state_q;
    logic [FILTER_WIDTH-1:0]   cnt_q;
    logic [FILTER_WIDTH-1:0]   filt_rise_q;
    logic [FILTER_WIDTH-1:0]   filt_fall_q;
    logic                      level_q;

    // Edge detection and pulse/count state
    logic                      level_prev_q;
    logic                      dout_q;
    logic                      dout_d;
    logic [TRIG_CNT_WIDTH-1:0] trig_cnt_q;
    logic [TRIG_CNT_WIDTH-1:0] trig_cnt_d;
    logic                      level_rose_s;
    logic                      level_fell_s;
    logic                      fire_s;

    // Two-flop synchroniser for the asynchronous trigger line.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_ff1_q  <= 1'b0;
            din_sync_q <= 1'b0;
        end else begin
            din_ff1_q  <= i_din;
            din_sync_q <= din_ff1_q;
        end
    end

    // Glitch filter FSM. cnt_q counts consecutive sightings of the new level,
    // the sighting that starts a check counting as the first, so a level is
    // accepted once it has been seen filt+1 times in a row. Filter widths are
    // sampled only while idle so a check always runs with one consistent width.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOW;
            cnt_q       <= FCNT_ZERO;
            filt_rise_q <= FCNT_ZERO;
            filt_fall_q <= FCNT_ZERO;
            level_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    filt_rise_q <= iv_filter_rise;
                    filt_fall_q <= iv_filter_fall;
                    if (din_sync_q) begin
                        if (filt_rise_q == FCNT_ZERO) begin
                            state_q <= ST_HIGH;
                            level_q <= 1'b1;
                            cnt_q   <= FCNT_ZERO;
                        end else begin
                            state_q <= ST_RISE_CHK;
                            cnt_q   <= FCNT_ONE;
                        end
                    end else begin
                        cnt_q <= FCNT_ZERO;
                    end
                end
                ST_RISE_CHK: begin
                    if (!din_sync_q) begin
                        state_q <= ST_LOW;
                        cnt_q   <= FCNT_ZERO;
                    end else if (cnt_q == filt_rise_q) begin
                        state_q <= ST_HIGH;
                        level_q <= 1'b1;
                        cnt_q   <= FCNT_ZERO;
                    end else begin
                        cnt_q <= cnt_q + FCNT_ONE;
                    end
                end
                ST_HIGH: begin
                    filt_rise_q <= iv_filter_rise;
                    filt_fall_q <= iv_filter_fall;
                    if (!din_sync_q) begin
                        if (filt_fall_q == FCNT_ZERO) begin
                            state_q <= ST_LOW;
                            level_q <= 1'b0;
                            cnt_q   <= FCNT_ZERO;
                        end else begin
                            state_q <= ST_FALL_CHK;
                            cnt_q   <= FCNT_ONE;
                        end
                    end else begin
                        cnt_q <= FCNT_ZERO;
                    end
                end
                ST_FALL_CHK: begin
                    if (din_sync_q) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= FCNT_ZERO;
                    end else if (cnt_q == filt_fall_q) begin
                        state_q <= ST_LOW;
                        level_q <= 1'b0;
                        cnt_q   <= FCNT_ZERO;
                    end else begin
                        cnt_q <= cnt_q + FCNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_LOW;
                    level_q <= 1'b0;
                    cnt_q   <= FCNT_ZERO;
                end
            endcase
        end
    end

    // Select the active edge of the filtered level and gate it with the mode.
    always_comb begin
        level_rose_s = level_q & ~level_prev_q;
        level_fell_s = ~level_q & level_prev_q;
        if (i_trigger_activation) begin
            fire_s = i_trigger_mode & level_fell_s;
        end else begin
            fire_s = i_trigger_mode & level_rose_s;
        end
        dout_d = fire_s;
        if (fire_s) begin
            trig_cnt_d = trig_cnt_q + TCNT_ONE;
        end else begin
            trig_cnt_d = trig_cnt_q;
        end
    end

    // Register the trigger pulse, the accepted-trigger count and the level history.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev_q <= 1'b0;
            dout_q       <= 1'b0;
            trig_cnt_q   <= TCNT_ZERO;
        end else begin
            level_prev_q <= level_q;
            dout_q       <= dout_d;
            trig_cnt_q   <= trig_cnt_d;
        end
    end

    assign o_level        = level_q;
    assign o_dout         = dout_q;
    assign ov_trigger_cnt = trig_cnt_q;

endmodule

// File: tb/tb_trigger_filter.sv
// Testbench for trigger_filter: table of line-pulse vectors plus hand-written
// sequences; expected trigger pulses are queued when stimulus is driven and
// popped when the DUT raises o_dout. A second instance with a 3-bit counter
// exercises counter wrap.
module tb_trigger_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        act;
    logic [15:0] fr;
    logic [15:0] ff;
    logic        din;
    logic        o_level;
    logic        o_dout;
    logic [15:0] ov_trigger_cnt;
    logic        level_w;
    logic        dout_w;
    logic [2:0]  cnt_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic        mode;
        logic        act;
        logic [15:0] fr;
        logic [15:0] ff;
        int          hi;
        int          lo;
        logic        rise_ok;
        logic        rise_pulse;
        logic        fall_pulse;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    vec_t        vecs[14];
    exp_t        sb[$];
    exp_t        e;
    logic [15:0] exp_cnt = 16'd0;

    trigger_filter #(.FILTER_WIDTH(16), .TRIG_CNT_WIDTH(16)) u_dut (
        .clk                  (clk),
        .reset                (reset),
        .i_trigger_mode       (mode),
        .i_trigger_activation (act),
        .iv_filter_rise       (fr),
        .iv_filter_fall       (ff),
        .i_din                (din),
        .o_level              (o_level),
        .o_dout               (o_dout),
        .ov_trigger_cnt       (ov_trigger_cnt)
    );

    trigger_filter #(.FILTER_WIDTH(16), .TRIG_CNT_WIDTH(3)) u_dut_w (
        .clk                  (clk),
        .reset                (reset),
        .i_trigger_mode       (mode),
        .i_trigger_activation (act),
        .iv_filter_rise       (fr),
        .iv_filter_fall       (ff),
        .i_din                (din),
        .o_level              (level_w),
        .o_dout               (dout_w),
        .ov_trigger_cnt       (cnt_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_pulse(input int at_cyc);
        exp_t x;
        exp_cnt  = exp_cnt + 16'd1;
        x.cyc    = at_cyc;
        x.cnt    = exp_cnt;
        sb.push_back(x);
    endfunction

    // Scoreboard: every o_dout pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_dout === 1'b1) begin
            if (sb.size() == 0) begin
                checks   = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_pulse actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_cnt", 32'(ov_trigger_cnt), 32'(e.cnt));
                check("pulse_cnt_w", 32'(cnt_w), 32'(e.cnt & 16'd7));
                check("pulse_dout_w", 32'(dout_w), 32'd1);
            end
        end
    end

    initial begin
        int n;

        //          mode  act   fr      ff      hi lo  rise_ok rise_p fall_p
        vecs[0]  = '{1'b1, 1'b0, 16'd3, 16'd0, 10, 8,  1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'd4, 16'd2, 4,  10, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'd4, 16'd2, 5,  10, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'd0, 16'd2, 8,  10, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 16'd2, 16'd1, 6,  8,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 16'd2, 16'd1, 6,  8,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'd2, 16'd1, 6,  8,  1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'd2, 16'd1, 6,  8,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'd2, 16'd1, 6,  8,  1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'd1, 16'd1, 4,  8,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'd0, 16'd0, 1,  7,  1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'd0, 16'd0, 3,  7,  1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 16'd7, 16'd1, 8,  9,  1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 16'd2, 16'd3, 2,  10, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; din = 1'b0; mode = 1'b0; act = 1'b0; fr = 16'd0; ff = 16'd0;
        repeat (3) tick();
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_dout", 32'(o_dout), 32'd0);
        check("rst_cnt", 32'(ov_trigger_cnt), 32'd0);
        check("rst_cnt_w", 32'(cnt_w), 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        // Basic rising trigger with a 3-clock rise filter: exact latency.
        mode = 1'b1; act = 1'b0; fr = 16'd3; ff = 16'd0;
        tick(); tick();
        din = 1'b1;
        n = cyc;
        push_pulse(n + 7);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) check("t1_level_e5", 32'(o_level), 32'd0);
            if (k == 6) begin
                check("t1_level_e6", 32'(o_level), 32'd1);
                check("t1_dout_e6", 32'(o_dout), 32'd0);
            end
            if (k == 7) begin
                check("t1_dout_e7", 32'(o_dout), 32'd1);
                check("t1_cnt_e7", 32'(ov_trigger_cnt), 32'd1);
            end
            if (k == 8) check("t1_dout_e8", 32'(o_dout), 32'd0);
        end
        din = 1'b0;
        repeat (8) tick();

        // Table-driven line pulses.
        for (int i = 0; i < 14; i++) begin
            mode = vecs[i].mode; act = vecs[i].act; fr = vecs[i].fr; ff = vecs[i].ff;
            din = 1'b1;
            n = cyc;
            if (vecs[i].rise_pulse) push_pulse(n + 4 + int'(vecs[i].fr));
            for (int k = 1; k <= vecs[i].hi + vecs[i].lo; k++) begin
                tick();
                if (k == vecs[i].hi) begin
                    din = 1'b0;
                    if (vecs[i].fall_pulse) push_pulse(cyc + 4 + int'(vecs[i].ff));
                end
                if (k == int'(vecs[i].fr) + 2)
                    check($sformatf("vec%0d_level_before_rise", i), 32'(o_level), 32'd0);
                if (k == int'(vecs[i].fr) + 3)
                    check($sformatf("vec%0d_level_after_rise", i), 32'(o_level), 32'(vecs[i].rise_ok));
                if (k == vecs[i].hi + int'(vecs[i].ff) + 2)
                    check($sformatf("vec%0d_level_before_fall", i), 32'(o_level), 32'(vecs[i].rise_ok));
                if (k == vecs[i].hi + int'(vecs[i].ff) + 3)
                    check($sformatf("vec%0d_level_after_fall", i), 32'(o_level), 32'd0);
            end
            check($sformatf("vec%0d_idle_level", i), 32'(o_level), 32'd0);
        end

        // Rise filter changed mid-check: current check keeps 3, next rise uses 10.
        mode = 1'b1; act = 1'b0; fr = 16'd3; ff = 16'd0;
        tick(); tick();
        din = 1'b1;
        n = cyc;
        push_pulse(n + 7);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) fr = 16'd10;
            if (k == 5) check("t5_level_e5", 32'(o_level), 32'd0);
            if (k == 6) check("t5_level_e6", 32'(o_level), 32'd1);
        end
        din = 1'b0;
        repeat (8) tick();
        din = 1'b1;
        n = cyc;
        push_pulse(n + 14);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 12) check("t5_level2_e12", 32'(o_level), 32'd0);
            if (k == 13) check("t5_level2_e13", 32'(o_level), 32'd1);
        end
        din = 1'b0;
        repeat (8) tick();
        check("t5_total_cnt", 32'(ov_trigger_cnt), 32'd9);
        check("t5_wrapped_cnt_w", 32'(cnt_w), 32'd1);

        // Reset during FALL_CHK discards the pending falling edge.
        act = 1'b1; fr = 16'd0; ff = 16'd10;
        din = 1'b1;
        repeat (6) tick();
        din = 1'b0;
        repeat (5) tick();
        check("t6_level_in_fall_chk", 32'(o_level), 32'd1);
        reset = 1'b1; act = 1'b0; fr = 16'd2; din = 1'b1;
        tick();
        check("t6_rst_level", 32'(o_level), 32'd0);
        check("t6_rst_dout", 32'(o_dout), 32'd0);
        check("t6_rst_cnt", 32'(ov_trigger_cnt), 32'd0);
        check("t6_rst_cnt_w", 32'(cnt_w), 32'd0);
        exp_cnt = 16'd0;
        tick();

        // Line already high at reset release counts as one rising edge.
        reset = 1'b0;
        n = cyc;
        push_pulse(n + 6);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) check("t7_level_e4", 32'(o_level), 32'd0);
            if (k == 5) check("t7_level_e5", 32'(o_level), 32'd1);
        end
        din = 1'b0;
        repeat (16) tick();
        check("final_level", 32'(o_level), 32'd0);
        check("final_level_w", 32'(level_w), 32'(o_level));
        check("final_cnt", 32'(ov_trigger_cnt), 32'd1);
        check("pending_pulses", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
